// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
//
// Elastic pipeline register with a valid/ready handshake on both sides and a
// two-entry skid buffer. It sits between two pipeline stages; the payload is
// typically {pc, instruction}.
//
// Handshake outputs (in_ready, out_valid, out_data) are decoded from
// registers only. Downstream backpressure therefore never reaches in_ready
// through combinational logic.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous kill of every buffered entry
//   cnt_clr      synchronous clear of both performance counters
//   in_valid     upstream offers in_data
//   in_ready     stage can accept (transfer on in_valid & in_ready)
//   in_data      upstream payload
//   out_valid    out_data holds a valid item
//   out_ready    downstream accepts (transfer on out_valid & out_ready)
//   out_data     payload to downstream, FLUSH_VALUE while out_valid=0
//   stall_count  saturating count of cycles with out_valid & ~out_ready
//   flush_count  saturating count of flush cycles that killed a valid entry
// -----------------------------------------------------------------------------
module elastic_pipe_reg #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [DATA_WIDTH-1:0]   main_r;
    logic [DATA_WIDTH-1:0]   main_nxt_s;
    logic [DATA_WIDTH-1:0]   skid_r;
    logic [DATA_WIDTH-1:0]   skid_nxt_s;
    logic                    acc_in_s;
    logic                    acc_out_s;
    logic [CNT_WIDTH-1:0]    stall_cnt_r;
    logic [CNT_WIDTH-1:0]    stall_cnt_nxt_s;
    logic [CNT_WIDTH-1:0]    flush_cnt_r;
    logic [CNT_WIDTH-1:0]    flush_cnt_nxt_s;

    // Handshake outputs decoded purely from the state register.
    assign out_valid = (state_r != ST_EMPTY);
    assign in_ready  = (state_r != ST_FULL);

    // main_r is reloaded with FLUSH_VALUE whenever the stage empties, so it
    // can drive out_data directly without a mux behind the state decode.
    assign out_data  = main_r;

    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;

    assign acc_in_s  = in_valid & in_ready;
    assign acc_out_s = out_valid & out_ready;

    // Next-state and next-payload logic; flush overrides the handshake.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            // Any item accepted this cycle is dropped; a delivery this cycle
            // still completes because out_valid/out_data were already shown.
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = FLUSH_VALUE;
            skid_nxt_s  = FLUSH_VALUE;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_in_s) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_in_s && acc_out_s) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_ONE;
                    end else if (acc_in_s) begin
                        // Downstream stalled: park the new item in the skid slot.
                        skid_nxt_s  = in_data;
                        state_nxt_s = ST_FULL;
                    end else if (acc_out_s) begin
                        main_nxt_s  = FLUSH_VALUE;
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (acc_out_s) begin
                        main_nxt_s  = skid_r;
                        skid_nxt_s  = FLUSH_VALUE;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = FLUSH_VALUE;
                    skid_nxt_s  = FLUSH_VALUE;
                end
            endcase
        end
    end

    // Next values of the saturating counters; clear beats increment.
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (cnt_clr) begin
            stall_cnt_nxt_s = CNT_ZERO;
            flush_cnt_nxt_s = CNT_ZERO;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_nxt_s = stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_nxt_s = stall_cnt_r;
            end
            if (flush && out_valid && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_nxt_s = flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_nxt_s = flush_cnt_r;
            end
        end
    end

    // State, payload and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= FLUSH_VALUE;
            skid_r      <= FLUSH_VALUE;
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_elastic_pipe_reg
//
// Testbench for elastic_pipe_reg. The driver pushes every accepted item into
// an ordered queue. A monitor process compares the DUT against that queue at
// every falling clock edge. A stage holding up to two items is fully
// described by this queue: out_valid = nonempty, in_ready = fewer than two,
// out_data = head. The monitor also keeps the two saturating counters from
// their definitions. The DUT is built with narrow counters so that
// saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_elastic_pipe_reg;

    localparam int             DW   = 16;
    localparam int             CW   = 4;
    localparam logic [DW-1:0]  FV   = 16'hDEAD;
    localparam logic [CW-1:0]  CMAX = 4'hF;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          cnt_clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    int            checks   = 0;
    int            failures = 0;
    int            accepted = 0;
    int            delivered = 0;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] exp_stall = 4'h0;
    logic [CW-1:0] exp_flush = 4'h0;

    elastic_pipe_reg #(
        .DATA_WIDTH (DW),
        .FLUSH_VALUE(FV),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_count(stall_count),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // One clock cycle. The accept decision is sampled at the falling edge,
    // where in_ready still shows the state of the current cycle. The item is
    // queued just after the rising edge. This keeps the queue stable while
    // the monitor runs at the falling edge.
    task automatic step();
        logic          p;
        logic [DW-1:0] d;
        @(negedge clk);
        p = in_valid & in_ready & ~flush & ~rst;
        d = in_data;
        @(posedge clk);
        if (p) begin
            exp_q.push_back(d);
            accepted++;
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        step();
    endtask

    // Monitor: compare against the queue model, then retire this cycle's
    // delivery and apply flush.
    initial begin
        logic          mv;
        logic          mr;
        logic [DW-1:0] md;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                exp_stall = 4'h0;
                exp_flush = 4'h0;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_data", 32'(out_data), 32'(FV));
                chk("rst_stall_count", 32'(stall_count), 32'd0);
                chk("rst_flush_count", 32'(flush_count), 32'd0);
            end else begin
                mv = (exp_q.size() != 0);
                mr = (exp_q.size() < 2);
                md = mv ? exp_q[0] : FV;
                chk("out_valid", 32'(out_valid), 32'(mv));
                chk("in_ready", 32'(in_ready), 32'(mr));
                chk("out_data", 32'(out_data), 32'(md));
                chk("stall_count", 32'(stall_count), 32'(exp_stall));
                chk("flush_count", 32'(flush_count), 32'(exp_flush));
                if (cnt_clr) begin
                    exp_stall = 4'h0;
                    exp_flush = 4'h0;
                end else begin
                    if (mv && !out_ready && exp_stall != CMAX) exp_stall = exp_stall + 4'h1;
                    if (flush && mv && exp_flush != CMAX) exp_flush = exp_flush + 4'h1;
                end
                if (mv && out_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #1;
        chk("por_out_valid", 32'(out_valid), 32'd0);
        chk("por_in_ready", 32'(in_ready), 32'd1);
        chk("por_out_data", 32'(out_data), 32'(FV));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming at full rate: items 1..4 follow each other, no stalls.
        for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("stream_stall_count", 32'(stall_count), 32'd0);

        // Backpressure: A held, B goes into the skid slot, 3 stall cycles.
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        chk("bp_stall_count", 32'(stall_count), 32'd3);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_data", 32'(out_data), 32'h000A);
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Flush while full and delivering: A counts as delivered, B is killed.
        drive(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'(FV));
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_count_one", 32'(flush_count), 32'd1);

        // Flush while empty: the offered item is dropped and not counted.
        drive(1'b1, 16'h0005, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("eflush_out_valid", 32'(out_valid), 32'd0);
        chk("eflush_flush_count", 32'(flush_count), 32'd1);

        // Stall counter saturation, then clear during a stall.
        drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("sat_stall_count", 32'(stall_count), 32'(CMAX));
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("clr_stall_count", 32'(stall_count), 32'd0);
        chk("clr_keeps_data", 32'(out_data), 32'h0011);

        // Asynchronous reset in mid-cycle while full.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", 32'(out_data), 32'(FV));
        step();
        rst = 1'b0;

        // Random traffic. Each cycle also toggles out_ready mid-cycle to show
        // that in_ready does not follow it combinationally.
        cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom);
            flush     = ($urandom_range(0, 31) == 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            #1;
            out_ready = ~out_ready;
            #1;
            chk("comb_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            out_ready = ~out_ready;
            step();
            cyc++;
        end

        // Drain what remains and confirm the stage ends empty.
        repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_out_data", 32'(out_data), 32'(FV));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Parametrised successor to the fixed IF/ID-style pipeline register. It replaces the global freeze signal with a per-stage valid/ready handshake and adds a 2-entry skid buffer, so backpressure never creates a combinational path from out_ready to in_ready. Flush kills all buffered entries. Saturating stall and flush counters support performance debug. It is instantiated between any two pipeline stages, typically with pc and instruction concatenated on the data bus.

Parameters:
DATA_WIDTH, 64, width of the payload carried per entry (e.g. {pc, instruction}).
FLUSH_VALUE, 0, payload value driven on out_data whenever out_valid=0 and loaded into entries on reset or flush.
CNT_WIDTH, 16, width of each saturating performance counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all buffered entries; highest priority after rst.
cnt_clr  input  1  synchronous clear of both counters.
in_valid  input  1  upstream offers in_data.
in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready.
in_data  input  DATA_WIDTH  upstream payload.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.
out_data  output  DATA_WIDTH  payload to downstream.
stall_count  output  CNT_WIDTH  cycles with out_valid=1 & out_ready=0, saturating.
flush_count  output  CNT_WIDTH  flush cycles that killed at least one valid entry, saturating.

Behaviour:
- Storage: main entry (drives out_data) and skid entry. State register with values EMPTY (0 entries), ONE (main valid), FULL (main and skid valid).
- Outputs derived from registers only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - out_data = main when out_valid=1, else FLUSH_VALUE.
  - No combinational path exists from any input to in_ready, out_valid or out_data.
- Define acc_in = in_valid & in_ready and acc_out = out_valid & out_ready.
- EMPTY:
  - acc_in: main <= in_data, go to ONE.
  - Otherwise stay in EMPTY.
- ONE:
  - acc_in & acc_out: main <= in_data, stay in ONE.
  - acc_in only: skid <= in_data, go to FULL.
  - acc_out only: go to EMPTY.
  - Neither: hold.
- FULL:
  - acc_out: main <= skid, go to ONE.
  - Otherwise hold. in_ready=0, so no input is accepted.
- Ordering: strict FIFO. An accepted item appears on out_data 1 cycle after acceptance when the stage was EMPTY, or immediately after older items drain. Full-throughput latency is 1 cycle and sustained rate is 1 item per cycle.
- Flush:
  - Next state is EMPTY; main and skid load FLUSH_VALUE.
  - An acc_in in the same cycle is discarded: upstream sees the handshake complete, but the data is killed.
  - An acc_out in the same cycle is a valid delivery; downstream keeps it.
- Reset (async, any time, including mid-transfer):
  - state=EMPTY, main=skid=FLUSH_VALUE, both counters=0.
  - Outputs immediately: out_valid=0, in_ready=1, out_data=FLUSH_VALUE.
- stall_count: +1 each cycle with out_valid & ~out_ready; holds at all-ones.
- flush_count: +1 each cycle with flush & (state != EMPTY); holds at all-ones.
- cnt_clr: both counters become 0 next cycle. When it coincides with an increment condition, clear wins. cnt_clr does not affect data or state.
- Priority: rst > flush > handshake logic. cnt_clr is independent of flush.

Test Plan:
- Reset, then in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 constantly -> out_data 1,2,3,4 on cycles 1..4; in_ready stays 1; stall_count=0.
- ONE holding 0xA, in_valid=1 data 0xB, out_ready=0 for 3 cycles -> state FULL and in_ready=0 from cycle 2; out_data holds 0xA; stall_count=3. Then out_ready=1 -> 0xA, then 0xB delivered; no loss or duplication.
- FULL (0xA, 0xB) with flush=1 and out_ready=1 in the same cycle -> 0xA counted delivered; next cycle out_valid=0, out_data=FLUSH_VALUE, in_ready=1; flush_count=1.
- EMPTY, flush=1 with in_valid=1 data 0x5 -> item dropped; out_valid stays 0; flush_count stays 0.
- Random in_valid/out_ready (50%) over 10k items with a scoreboard -> output sequence equals input sequence; in_ready never depends combinationally on out_ready.
- CNT_WIDTH=4 with 20 stall cycles -> stall_count saturates at 15. Assert cnt_clr together with a stall -> 0. Assert rst while FULL -> immediate out_valid=0, in_ready=1.
